// File: rtl/npc_ras_unit.sv
// Next-PC selection with fetch PC / EPC registers and a circular return-address stack.
// The stack publishes a predicted return target for jr $ra; it is a hint only and never steers pc.
module npc_ras_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter int unsigned RAS_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] dpc4,
    input  logic [25:0] imm26,
    input  logic        branch,
    input  logic        j,
    input  logic        jr,
    input  logic [31:0] rs_val,
    input  logic        link,
    input  logic        jr_ra,
    input  logic        exc,
    input  logic        bd,
    input  logic [31:0] exc_pc,
    input  logic        eret,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic [31:0] ras_top,
    output logic        ras_valid,
    output logic        adel
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [31:0]      entry [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [CNT_W-1:0] count;

    logic [31:0]      br_off;
    logic [31:0]      pc_next;
    logic [31:0]      ret_addr;
    logic [PTR_W-1:0] top_inc;
    logic [PTR_W-1:0] top_dec;
    logic             ras_en;
    logic             ras_empty;
    logic             do_push;
    logic             do_replace;
    logic             do_pop;

    // Next-PC priority: exception and eret override stall; redirects only when not stalled.
    always_comb begin
        br_off  = {{14{imm26[15]}}, imm26[15:0], 2'b00};
        pc_next = pc + 32'd4;
        if (exc) begin
            pc_next = EXC_VECTOR;
        end else if (eret) begin
            pc_next = epc;
        end else if (stall) begin
            pc_next = pc;
        end else if (jr) begin
            pc_next = rs_val;
        end else if (j) begin
            pc_next = {dpc4[31:28], imm26, 2'b00};
        end else if (branch) begin
            pc_next = dpc4 + br_off;
        end
    end

    // jalr $31 replaces the top in place, except on an empty stack where it acts as a push.
    always_comb begin
        ret_addr   = dpc4 + 32'd4;
        top_inc    = top + PTR_W'(1);
        top_dec    = top - PTR_W'(1);
        ras_empty  = (count == '0);
        ras_en     = !stall && !exc;
        do_push    = ras_en && link && (!jr_ra || ras_empty);
        do_replace = ras_en && link && jr_ra && !ras_empty;
        do_pop     = ras_en && jr_ra && !link && !ras_empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            epc   <= '0;
            top   <= '0;
            count <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                entry[i] <= '0;
            end
        end else begin
            pc <= pc_next;
            if (exc) begin
                epc <= bd ? (exc_pc - 32'd4) : exc_pc;
            end
            // A full stack wraps and silently overwrites its oldest entry.
            if (do_push) begin
                entry[top_inc] <= ret_addr;
                top            <= top_inc;
                if (count != CNT_W'(RAS_DEPTH)) begin
                    count <= count + CNT_W'(1);
                end
            end else if (do_replace) begin
                entry[top] <= ret_addr;
            end else if (do_pop) begin
                top   <= top_dec;
                count <= count - CNT_W'(1);
            end
        end
    end

    assign ras_valid = (count != '0);
    assign ras_top   = (count != '0) ? entry[top] : 32'd0;
    assign adel      = (pc[1:0] != 2'b00);

endmodule

// File: tb/tb_npc_ras_unit.sv
// Directed bench for npc_ras_unit: driver queues hand-computed expectations, monitor checks them.
module tb_npc_ras_unit;

    logic        clk = 1'b0;
    logic        reset, stall, branch, j, jr, link, jr_ra, exc, bd, eret;
    logic [31:0] dpc4, rs_val, exc_pc;
    logic [25:0] imm26;
    logic [31:0] pc, epc, ras_top;
    logic        ras_valid, adel;

    int tests = 0;
    int fails = 0;

    localparam int M_PC = 1, M_EPC = 2, M_RT = 4, M_RV = 8, M_AD = 16;
    localparam int M_RAS = M_RT | M_RV;
    localparam int M_ALL = 31;

    typedef struct {
        string       name;
        logic [4:0]  m;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] rt;
        logic        rv;
        logic        ad;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    npc_ras_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .dpc4(dpc4), .imm26(imm26),
        .branch(branch), .j(j), .jr(jr), .rs_val(rs_val), .link(link),
        .jr_ra(jr_ra), .exc(exc), .bd(bd), .exc_pc(exc_pc), .eret(eret),
        .pc(pc), .epc(epc), .ras_top(ras_top), .ras_valid(ras_valid), .adel(adel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s got=%h expected=%h", nm, f, act, exp);
        end
    endtask

    // Monitor: outputs settle one cycle after each queued stimulus; compare just after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.m[0]) chk(mon_e.name, "pc", pc, mon_e.pc);
            if (mon_e.m[1]) chk(mon_e.name, "epc", epc, mon_e.epc);
            if (mon_e.m[2]) chk(mon_e.name, "ras_top", ras_top, mon_e.rt);
            if (mon_e.m[3]) chk(mon_e.name, "ras_valid", 32'(ras_valid), 32'(mon_e.rv));
            if (mon_e.m[4]) chk(mon_e.name, "adel", 32'(adel), 32'(mon_e.ad));
        end
    end

    task automatic clr();
        reset = 0; stall = 0; branch = 0; j = 0; jr = 0; link = 0; jr_ra = 0;
        exc = 0; bd = 0; eret = 0; dpc4 = '0; rs_val = '0; exc_pc = '0; imm26 = '0;
    endtask

    // Queue the expectation for the coming edge, let it happen, then clear inputs.
    task automatic step(input string nm, input int m, input logic [31:0] p, input logic [31:0] e,
                        input logic [31:0] rt, input logic rv, input logic ad);
        exp_t x;
        x.name = nm; x.m = 5'(m); x.pc = p; x.epc = e; x.rt = rt; x.rv = rv; x.ad = ad;
        exp_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
        clr();
    endtask

    task automatic push(input string nm, input logic [31:0] d, input logic [31:0] rt);
        link = 1; dpc4 = d;
        step(nm, M_RAS, 0, 0, rt, 1'b1, 1'b0);
    endtask

    task automatic pop(input string nm, input logic [31:0] rt, input logic rv);
        jr_ra = 1;
        step(nm, M_RAS, 0, 0, rt, rv, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        reset = 1;
        @(negedge clk);
        reset = 1;
        step("reset", M_ALL, 32'h3000, 0, 0, 0, 0);
        step("seq1", M_PC | M_EPC | M_RV, 32'h3004, 0, 0, 0, 0);
        step("seq2", M_PC, 32'h3008, 0, 0, 0, 0);
        step("seq3", M_PC | M_AD, 32'h300C, 0, 0, 0, 0);

        dpc4 = 32'h3010; imm26 = 26'h000FFFC; branch = 1;
        step("branch_back", M_PC, 32'h3000, 0, 0, 0, 0);
        dpc4 = 32'h3010; imm26 = 26'h0000C10; j = 1;
        step("jump", M_PC, 32'h3040, 0, 0, 0, 0);
        jr = 1; rs_val = 32'h3100;
        step("jr", M_PC | M_AD, 32'h3100, 0, 0, 0, 0);

        for (int i = 0; i < 3; i++) begin
            stall = 1; dpc4 = 32'h3010; j = 1; imm26 = 26'h0000C10;
            step($sformatf("stall%0d", i), M_PC, 32'h3100, 0, 0, 0, 0);
        end
        stall = 1; exc = 1; exc_pc = 32'h3024; bd = 1;
        step("exc_over_stall", M_PC | M_EPC, 32'h4180, 32'h3020, 0, 0, 0);
        eret = 1;
        step("eret", M_PC | M_EPC, 32'h3020, 32'h3020, 0, 0, 0);
        step("after_eret", M_PC, 32'h3024, 0, 0, 0, 0);

        push("push0", 32'h3000, 32'h3004);
        push("push1", 32'h3010, 32'h3014);
        push("push2", 32'h3020, 32'h3024);
        push("push3", 32'h3030, 32'h3034);
        push("push4_wrap", 32'h3040, 32'h3044);
        pop("pop0", 32'h3034, 1);
        pop("pop1", 32'h3024, 1);
        pop("pop2", 32'h3014, 1);
        pop("pop3_empty", 32'h0, 0);
        pop("pop_on_empty", 32'h0, 0);

        push("pushA", 32'h3100, 32'h3104);
        push("pushB", 32'h3200, 32'h3204);
        link = 1; jr_ra = 1; dpc4 = 32'h3050;
        step("push_pop_replace", M_RAS, 0, 0, 32'h3054, 1, 0);
        pop("pop_after_replace", 32'h3104, 1);
        stall = 1; link = 1; dpc4 = 32'h3300;
        step("push_stalled", M_RAS, 0, 0, 32'h3104, 1, 0);
        exc = 1; link = 1; dpc4 = 32'h3300; exc_pc = 32'h3010; bd = 0;
        step("push_exc", M_ALL, 32'h4180, 32'h3010, 32'h3104, 1, 0);
        pop("pop_last", 32'h0, 0);
        link = 1; jr_ra = 1; dpc4 = 32'h3400;
        step("push_pop_empty", M_RAS, 0, 0, 32'h3404, 1, 0);
        eret = 1;
        step("eret_keeps_ras", M_ALL, 32'h3010, 32'h3010, 32'h3404, 1, 0);

        jr = 1; rs_val = 32'h3102;
        step("misalign", M_PC | M_AD, 32'h3102, 0, 0, 0, 1);
        exc = 1; exc_pc = 32'h3102;
        step("misalign_exc", M_PC | M_EPC | M_AD, 32'h4180, 32'h3102, 0, 0, 0);

        dpc4 = 32'h3004; imm26 = 26'h0000010; branch = 1;
        step("branch_fwd", M_PC, 32'h3044, 0, 0, 0, 0);
        reset = 1; jr = 1; rs_val = 32'h5000; link = 1; dpc4 = 32'h3600;
        step("reset_midop", M_ALL, 32'h3000, 0, 0, 0, 0);
        step("post_reset", M_PC | M_RV, 32'h3004, 0, 0, 0, 0);

        @(negedge clk);
        chk("drain", "queue_left", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/npc_ras_unit.md
Name: npc_ras_unit

Overview:
- Successor to the combinational next-PC logic for the pipelined MIPS core; sits in the F/D boundary.
- Owns the architectural fetch PC register and selects the next PC from: sequential, branch, j/jal, jr/jalr, exception entry and eret.
- Captures EPC on exception entry.
- Adds a parametrised circular return-address stack (RAS) that publishes a predicted return target for `jr $ra`.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, exception/interrupt handler entry.
- RAS_DEPTH, 4, number of RAS entries (power of two, 2..16).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold PC and RAS; no update this cycle.
- dpc4  in  32  PC+4 of the instruction currently in D (base for branch/j).
- imm26  in  26  instr_index field; [15:0] is the branch offset.
- branch  in  1  D-stage branch resolved taken.
- j  in  1  j/jal in D.
- jr  in  1  jr/jalr in D.
- rs_val  in  32  forwarded GPR[rs] for jr/jalr.
- link  in  1  jal/jalr in D (RAS push).
- jr_ra  in  1  jr with rs==31 (RAS pop).
- exc  in  1  exception/interrupt accepted this cycle.
- bd  in  1  excepting instruction is in a delay slot.
- exc_pc  in  32  PC of excepting instruction.
- eret  in  1  eret committed.
- pc  out  32  current fetch PC (registered).
- epc  out  32  saved exception PC (registered).
- ras_top  out  32  RAS top entry (predicted return).
- ras_valid  out  1  RAS non-empty.
- adel  out  1  pc[1:0]!=0 (combinational from pc).

Behaviour:
- Reset (synchronous, active-high):
  - pc=RESET_PC, epc=0.
  - RAS count=0, top pointer=0, ras_valid=0, ras_top=0 (all entries cleared).
  - adel=0.
- Next-PC priority, evaluated each cycle, registered into pc on the edge:
  1. reset -> RESET_PC
  2. exc -> EXC_VECTOR (ignores stall)
  3. eret -> epc (ignores stall)
  4. stall -> pc unchanged
  5. jr -> rs_val
  6. j -> {dpc4[31:28], imm26, 2'b00}
  7. branch -> dpc4 + (sign-extended imm26[15:0] << 2), 32-bit wraparound, no overflow flag
  8. otherwise -> pc+4
- Only one of jr/j/branch is legal at a time; if several assert, the priority above still applies.
- EPC: on exc, epc <= bd ? exc_pc-4 : exc_pc. It is held otherwise and is not written by eret.
- Simultaneous exc and eret: exc wins, and epc is updated.
- RAS update is gated by !stall && !exc && !reset; eret does not affect the RAS.
  - push (link && !jr_ra):
    - entry[top+1] <= dpc4+4, top <= top+1 mod RAS_DEPTH.
    - count <= min(count+1, RAS_DEPTH).
    - When full, the oldest entry is silently overwritten.
  - pop (jr_ra && !link) with count>0: top <= top-1 mod RAS_DEPTH, count <= count-1.
  - pop on empty: no change, no error.
  - push+pop together (jalr $31): entry[top] <= dpc4+4; top and count are unchanged. If empty, this behaves as a push.
- ras_top = entry[top] when count>0, else 0. ras_valid = (count!=0). Both are registered-state derived, with no combinational path from inputs.
- Latency: a redirect requested in cycle N appears on pc after edge N. A RAS push in cycle N is visible on ras_top after edge N.
- Reset mid-operation discards any pending redirect and clears the RAS completely.

Test Plan:
- Reset/sequential: assert reset 1 cycle, then idle 3 cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C; epc=0; ras_valid=0.
- Branch/jump:
  - dpc4=0x3010, imm26[15:0]=0xFFFC, branch=1 -> pc=0x3000.
  - dpc4=0x3010, imm26=0x0000C10, j=1 -> pc=0x3040.
  - jr=1 with rs_val=0x3100 -> pc=0x3100.
- Stall vs exception:
  - stall=1 holds pc for 3 cycles.
  - exc=1 while stall=1, exc_pc=0x3024, bd=1 -> pc=0x4180, epc=0x3020.
  - eret next cycle -> pc=0x3020.
- RAS overflow (RAS_DEPTH=4): 5 pushes with dpc4=0x3000,0x3010,0x3020,0x3030,0x3040 -> ras_top=0x3044. Then 4 pops -> ras_top 0x3034, 0x3024, 0x3014, then ras_valid=0. A 5th pop causes no change.
- RAS corner cases:
  - link+jr_ra together with dpc4=0x3050 on a non-empty stack -> top replaced by 0x3054, count unchanged.
  - Push with stall=1 or exc=1 -> RAS unchanged.
- Misalignment: jr with rs_val=0x3102 -> pc=0x3102, adel=1. A following exc -> pc=0x4180, adel=0.
